// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-and-add multiplier, signed/unsigned, start/busy/done
// One partial product per clock on operand magnitudes; sign is applied when the result is stored.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_next;

  // Magnitudes as WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    mag_a    = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b    = (signed_mode && b[WIDTH-1]) ? -b : b;
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= neg ? -acc_next : acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (WIDTH 8, plus 4 and 16 sweeps)
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vectors = 0;
  int errors  = 0;
  logic [1:0] sweep_go  = 2'b00;
  logic [1:0] sweep_fin = 2'b00;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after the start edge; returns the cycle count to done (-1 on timeout).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run8(input logic m, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int lat);
    start = 1'b1; sm = m; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; sm = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    wait_done(lat);
    p = product;
  endtask

  function automatic logic [15:0] ref8(input logic m, input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    sx = m ? int'($signed(x)) : int'(x);
    sy = m ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  typedef struct {
    logic        m;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp;
  } vec_t;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int SW = (gi == 0) ? 4 : 16;
      logic            s_start = 1'b0;
      logic            s_sm = 1'b0;
      logic [SW-1:0]   s_a = '0;
      logic [SW-1:0]   s_b = '0;
      logic            s_busy;
      logic            s_done;
      logic [2*SW-1:0] s_prod;

      seq_multiplier #(.WIDTH(SW)) u_dut (
        .clk(clk), .rst(rst), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .product(s_prod)
      );

      initial begin
        logic                   m;
        logic [SW-1:0]          x, y;
        logic signed [2*SW-1:0] sx, sy;
        logic [2*SW-1:0]        ex;
        int                     lat;
        wait (sweep_go[gi]);
        @(posedge clk); #1;
        for (int n = 0; n < 1000; n++) begin
          m = 1'($urandom); x = SW'($urandom); y = SW'($urandom);
          if (n < 4) begin
            x = (n < 2) ? {1'b1, {(SW-1){1'b0}}} : '0;
            y = {1'b1, {(SW-1){1'b0}}};
          end
          if (m) begin
            sx = $signed(x); sy = $signed(y); ex = sx * sy;
          end else begin
            ex = {{SW{1'b0}}, x} * {{SW{1'b0}}, y};
          end
          s_start = 1'b1; s_sm = m; s_a = x; s_b = y;
          @(posedge clk); #1;
          s_start = 1'b0; s_a = SW'($urandom); s_b = SW'($urandom);
          lat = -1;
          for (int k = 1; k <= SW + 8; k++) begin
            @(posedge clk); #1;
            if (s_done) begin
              lat = k;
              break;
            end
          end
          chk($sformatf("w%0d_product m=%0d a=%0h b=%0h", SW, m, x, y), 64'(s_prod), 64'(ex));
          chk($sformatf("w%0d_latency", SW), 64'(lat), 64'(SW));
        end
        sweep_fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    vec_t        tbl[8];
    logic [15:0] p;
    logic        m;
    logic [7:0]  x, y;
    int          lat, ndone, nbusy;

    tbl[0] = '{1'b0, 8'd10,  8'd12,  16'h0078};
    tbl[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{1'b0, 8'd0,   8'd200, 16'h0000};
    tbl[3] = '{1'b1, 8'hFD,  8'd5,   16'hFFF1};
    tbl[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    tbl[5] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    tbl[6] = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
    tbl[7] = '{1'b0, 8'h80,  8'h80,  16'h4000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].m, tbl[i].x, tbl[i].y, p, lat);
      chk($sformatf("table%0d_product", i), 64'(p), 64'(tbl[i].exp));
      chk($sformatf("table%0d_latency", i), 64'(lat), 64'd8);
      @(posedge clk); #1;
      chk($sformatf("table%0d_done_width", i), 64'(done), 64'd0);
      chk($sformatf("table%0d_product_hold", i), 64'(product), 64'(tbl[i].exp));
    end

    // Back-to-back: new start issued in the done cycle.
    run8(1'b0, 8'd10, 8'd12, p, lat);
    chk("b2b_first", 64'(p), 64'h0078);
    run8(1'b0, 8'd13, 8'd12, p, lat);
    chk("b2b_second", 64'(p), 64'h009C);
    chk("b2b_latency", 64'(lat), 64'd8);

    // Start held high during RUN with operands changing.
    start = 1'b1; sm = 1'b0; a = 8'd7; b = 8'd9;
    @(posedge clk);
    ndone = 0; nbusy = 0;
    for (int k = 0; k <= 8; k++) begin
      #1;
      if (busy) nbusy++;
      if (done) ndone++;
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      if (k == 8) begin
        chk("hold_product", 64'(product), 64'd63);
        start = 1'b0;
      end
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done) ndone++;
      @(posedge clk);
    end
    #1;
    chk("hold_done_count", 64'(ndone), 64'd1);
    chk("hold_busy_cycles", 64'(nbusy), 64'd8);

    // Reset during iteration 4 aborts the operation.
    start = 1'b1; sm = 1'b0; a = 8'd100; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run8(1'b1, 8'hF6, 8'd11, p, lat);
    chk("after_abort_product", 64'(p), 64'hFF92);
    chk("after_abort_latency", 64'(lat), 64'd8);

    for (int n = 0; n < 200; n++) begin
      m = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      run8(m, x, y, p, lat);
      chk($sformatf("rand8 m=%0d a=%0h b=%0h", m, x, y), 64'(p), 64'(ref8(m, x, y)));
      chk("rand8_latency", 64'(lat), 64'd8);
    end

    sweep_go[0] = 1'b1;
    wait (sweep_fin[0]);
    sweep_go[1] = 1'b1;
    wait (sweep_fin[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-and-add multiplier; next generation of the team's 4x4 combinational array multiplier.
- Generalised operand width; selectable signed (two's complement) or unsigned mode per operation.
- Start/busy/done handshake; one partial product per clock, so area stays flat as WIDTH grows.
- Intended as the multi-cycle MUL unit beside the RISC-V datapath ALU.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  result; held until the next completion or reset

Behaviour:
- Reset: one clock, synchronous and active-high. State goes to IDLE. busy=0, done=0, product=0, internal registers=0.
- Reset has priority over everything. Asserting rst mid-operation aborts it: no done pulse and product=0.
- States:
  - IDLE: busy=0. If start=1 at an edge E0, latch a, b and signed_mode, clear the accumulator and the bit counter, and go to RUN. busy=1 from E0.
  - RUN: one iteration per edge. If the current multiplier bit is 1, add the shifted multiplicand magnitude to the 2*WIDTH accumulator. Then shift and increment the counter. Iterations occur at edges E1..EWIDTH.
  - On edge EWIDTH: product <= sign-corrected accumulator, done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after edge E(WIDTH), i.e. WIDTH cycles after the start edge. Throughput is one result per WIDTH cycles.
- done is high for exactly one cycle. product stays stable after done falls.
- Back-to-back: start=1 in the cycle where done=1 is accepted, since state is IDLE.
- start while busy=1 is ignored. No queuing, no effect on the result. a, b and signed_mode may change freely during RUN.
- Unsigned mode: operands are zero-extended; product is the exact 2*WIDTH unsigned product.
- Signed mode:
  - Multiply the magnitudes. |a| and |b| are taken as WIDTH-bit unsigned, so -2^(WIDTH-1) has magnitude 2^(WIDTH-1).
  - Negate the result in two's complement if sign(a) XOR sign(b).
  - Every result fits 2*WIDTH bits, including (-2^(W-1))^2 = 2^(2W-2).
- A zero operand gives product=0; the full WIDTH cycles are still taken (no early termination).

Test Plan:
- WIDTH=8, unsigned: a=10, b=12 -> done after 8 cycles, product=16'h0078. Back-to-back start in the done cycle with a=13, b=12 -> product=16'h009C.
- Unsigned extremes: a=255, b=255 -> 16'hFE01. a=0, b=200 -> 16'h0000 with done still at 8 cycles.
- Signed: a=-3 (8'hFD), b=5 -> 16'hFFF1. a=-128, b=-128 -> 16'h4000. a=-128, b=127 -> 16'hC080. a=127, b=127 -> 16'h3F01.
- Handshake: start held high and a, b changed during RUN -> exactly one done per accepted start. Result matches the operands sampled at the accepting edge. busy high for 8 cycles.
- Reset mid-operation: rst=1 at iteration 4 -> next cycle busy=0, done=0, product=0, and no done pulse follows. A new start then completes normally.
- Parameter sweep: WIDTH=4 and WIDTH=16, random a, b and signed_mode over 1000 operations -> product equals the reference $signed/$unsigned product; done exactly WIDTH cycles after start.
